// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: clocked instruction memory with init engine and fetch port.
// Optional parity storage/check enabled by defining INSTR_MEM_PARITY_EN.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   fetch_req/fetch_addr   fetch request (valid) and word address
//   fetch_ready            request accepted when fetch_req && fetch_ready
//   instr_valid/instr      registered fetched word, held while stalled
//   instr_ready            downstream consume strobe
//   addr_err               instr came from an out-of-range address
//   wr_en/wr_addr/wr_data  program-load write port (RUN state only)
//   init_done              init engine finished
//   parity_err, inj_par    (INSTR_MEM_PARITY_EN only) parity check / inject
module instr_mem_fetch #(
   parameter int DATA_W        = 16,
   parameter int ADDR_W        = 3,
   parameter int DEPTH         = 8,
   parameter int DEFAULT_INSTR = 50
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   input  logic              instr_ready,
   output logic              addr_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef INSTR_MEM_PARITY_EN
   output logic              parity_err,
   input  logic              inj_par,
`endif
   output logic              init_done
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] init_word;
   logic              fetch_in;
   logic              wr_in;
   logic              accept;
   logic              wr_ok;
   logic              cnt_last;

   // A full-size array makes every address legal; avoid a constant compare.
   if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign fetch_in = 1'b1;
      assign wr_in    = 1'b1;
   end else begin : g_part
      assign fetch_in = 32'(fetch_addr) < DEPTH;
      assign wr_in    = 32'(wr_addr) < DEPTH;
   end

   assign init_word   = DATA_W'({cnt, 1'b0});
   assign cnt_last    = (cnt == ADDR_W'(DEPTH - 1));
   assign fetch_ready = (state == RUN) && (!instr_valid || instr_ready);
   assign accept      = fetch_req && fetch_ready;
   assign wr_ok       = (state == RUN) && wr_en && wr_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= '0;
         init_done <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               if (cnt_last) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: state <= INIT;
         endcase
      end
   end

   // Array is not reset; the init engine rewrites it after every reset.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[cnt] <= init_word;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef INSTR_MEM_PARITY_EN
   logic par [DEPTH];

   always_ff @(posedge clk) begin
      if (state == INIT) begin
         par[cnt] <= ^init_word;
      end else if (wr_ok) begin
         par[wr_addr] <= (^wr_data) ^ inj_par;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else if (accept) begin
         parity_err <= fetch_in
                       ? ((^mem[fetch_addr]) ^ par[fetch_addr])
                       : 1'b0;
      end
   end
`endif

   // Reads sample the array before this edge's write lands,
   // so a same-cycle write/fetch returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_valid <= 1'b0;
         instr       <= '0;
         addr_err    <= 1'b0;
      end else if (accept) begin
         instr_valid <= 1'b1;
         if (fetch_in) begin
            instr    <= mem[fetch_addr];
            addr_err <= 1'b0;
         end else begin
            instr    <= DATA_W'(DEFAULT_INSTR);
            addr_err <= 1'b1;
         end
      end else if (instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule
